subbytes_engine: RTL and testbench

Parametrised, sequential AES SubBytes/InvSubBytes unit for the SIMD execute stage. It accepts a STATE_W-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through internal forward and inverse S-Box ROMs. It returns the substituted state over a second valid/ready handshake. It replaces the flat combinational substitution with an area-scalable engine: fewer lanes means fewer S-Box instances and more cycles.

---
 rtl/subbytes_engine.sv | 145 ++++++++++++++
 tb/tb_subbytes_engine.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subbytes_engine.sv
// subbytes_engine: lane-scalable AES SubBytes/InvSubBytes engine, LANES bytes per cycle.
// Define SUBBYTES_ENGINE_INVERSE_EN to build the inverse S-Box and honour in_inverse.
module subbytes_engine #(
    parameter int STATE_W = 128,
    parameter int LANES   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               in_inverse,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);
    localparam int NBYTES  = STATE_W / 8;
    localparam int NCHUNK  = (LANES > 0) ? NBYTES / LANES : 1;
    localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CHUNK_W = 8 * LANES;

    if ((STATE_W % 8) != 0 || STATE_W < 8 || LANES < 1 ||
        (NBYTES % ((LANES > 0) ? LANES : 1)) != 0) begin : g_bad_params
        $error("subbytes_engine: LANES=%0d must divide STATE_W/8 (STATE_W=%0d)", LANES, STATE_W);
    end

    // FIPS-197 forward S-Box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rom_read(input logic [2047:0] rom, input logic [7:0] idx);
        return rom[(255 - int'(idx)) * 8 +: 8];
    endfunction

`ifdef SUBBYTES_ENGINE_INVERSE_EN
    // Derived from the forward table so the two can never disagree.
    function automatic logic [2047:0] invert_rom(input logic [2047:0] rom);
        logic [2047:0] inv;
        inv = '0;
        for (int i = 0; i < 256; i++) begin
            inv[(255 - int'(rom[(255 - i) * 8 +: 8])) * 8 +: 8] = 8'(i);
        end
        return inv;
    endfunction

    localparam logic [2047:0] SBOX_INV = invert_rom(SBOX_FWD);

    logic mode;
`else
    logic unused_inverse;
    assign unused_inverse = in_inverse;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CHUNK_W-1:0] chunk_in;
    logic [CHUNK_W-1:0] chunk_out;

    assign chunk_in = out_state[int'(cnt) * CHUNK_W +: CHUNK_W];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] lane_byte;
        logic [7:0] lane_fwd;
        assign lane_byte = chunk_in[8*l +: 8];
        assign lane_fwd  = rom_read(SBOX_FWD, lane_byte);
`ifdef SUBBYTES_ENGINE_INVERSE_EN
        assign chunk_out[8*l +: 8] = mode ? rom_read(SBOX_INV, lane_byte) : lane_fwd;
`else
        assign chunk_out[8*l +: 8] = lane_fwd;
`endif
    end

    // out_state doubles as the work register; chunks are overwritten in place, lowest first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_state <= '0;
            cnt       <= '0;
`ifdef SUBBYTES_ENGINE_INVERSE_EN
            mode      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_state <= in_state;
                        cnt       <= '0;
                        state     <= RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
`ifdef SUBBYTES_ENGINE_INVERSE_EN
                        mode      <= in_inverse;
`endif
                    end
                end
                RUN: begin
                    out_state[int'(cnt) * CHUNK_W +: CHUNK_W] <= chunk_out;
                    if (cnt == CNT_W'(NCHUNK - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subbytes_engine.sv
// Directed and randomized self-checking bench for subbytes_engine, including a LANES sweep.
// Honors SUBBYTES_ENGINE_INVERSE_EN when deciding inverse-mode expectations.
`timescale 1ns/1ps
module tb_subbytes_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inverse;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    always #5 clk = ~clk;

    subbytes_engine #(.STATE_W(128), .LANES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .in_inverse (in_inverse),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_state  (out_state),
        .busy       (busy)
    );

    // Extra instances for the latency sweep: LANES = 1, 2, 8, 16.
    logic         sw_valid;
    logic [127:0] sw_state;
    logic         sw_in_ready  [4];
    logic         sw_out_valid [4];
    logic [127:0] sw_out_state [4];
    logic         sw_busy      [4];

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        subbytes_engine #(.STATE_W(128), .LANES((g < 2) ? (1 << g) : (8 << (g - 2)))) dut_sw (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (sw_valid),
            .in_ready   (sw_in_ready[g]),
            .in_state   (sw_state),
            .in_inverse (1'b0),
            .out_valid  (sw_out_valid[g]),
            .out_ready  (1'b1),
            .out_state  (sw_out_state[g]),
            .busy       (sw_busy[g])
        );
    end

    localparam logic [2047:0] FWD_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] VEC_IN   = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] VEC_FWD  = 128'h1628c14beaaceec4f533fc1bc3938263;
    localparam logic [127:0] VEC_FWD2 = 128'h473478b38791281ce6c3b0af2edc13fb;

    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];
    int           num_compared;
    int           num_mismatched;
    logic [127:0] exp_q [$];
    logic [127:0] rand_states [100];
    logic         rand_modes  [100];

    function automatic logic eff_mode(input logic inv);
`ifdef SUBBYTES_ENGINE_INVERSE_EN
        return inv;
`else
        return 1'b0 & inv;
`endif
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = inv ? inv_tab[s[8*i +: 8]] : fwd_tab[s[8*i +: 8]];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        num_compared++;
        if (got !== exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction: offer, accept, then count edges until out_valid.
    task automatic applyStimulus(input logic [127:0] st, input logic inv, input logic rdy,
                                 output logic [127:0] res, output int lat);
        lat = 0;
        res = '0;
        @(negedge clk);
        in_state   = st;
        in_inverse = inv;
        in_valid   = 1'b1;
        out_ready  = rdy;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                res = out_state;
                break;
            end
        end
    endtask

    logic [127:0] res;
    int           lat;
    logic [127:0] bp_exp;
    int           sw_lat [4];
    logic [127:0] sw_res [4];
    int           exp_lat [4];
    logic         saw_valid;
    int           sent;
    int           received;

    initial begin
        num_compared   = 0;
        num_mismatched = 0;
        for (int i = 0; i < 256; i++) fwd_tab[i] = FWD_ROM[(255 - i) * 8 +: 8];
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_state   = '0;
        in_inverse = 1'b0;
        out_ready  = 1'b1;
        sw_valid   = 1'b0;
        sw_state   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_in_ready",  128'(in_ready),  128'd1);
        checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset_busy",      128'(busy),      128'd0);
        checkOutput("reset_out_state", out_state,       128'd0);

        applyStimulus(VEC_IN, 1'b0, 1'b1, res, lat);
        checkOutput("fwd_vec",     res,        VEC_FWD);
        checkOutput("fwd_latency", 128'(lat),  128'd4);

        applyStimulus(VEC_FWD, 1'b1, 1'b1, res, lat);
`ifdef SUBBYTES_ENGINE_INVERSE_EN
        checkOutput("inv_vec", res, VEC_IN);
`else
        checkOutput("inv_ignored_vec", res, VEC_FWD2);
`endif

        applyStimulus('0, 1'b0, 1'b1, res, lat);
        checkOutput("all_zero", res, {16{8'h63}});
        applyStimulus('1, 1'b0, 1'b1, res, lat);
        checkOutput("all_ff", res, {16{8'h16}});

        // Reset asserted while the engine is in RUN.
        @(negedge clk);
        in_state  = VEC_IN;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrun_busy", 128'(busy), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_rst_in_ready",  128'(in_ready),  128'd1);
        checkOutput("midrun_rst_out_valid", 128'(out_valid), 128'd0);
        checkOutput("midrun_rst_busy",      128'(busy),      128'd0);
        checkOutput("midrun_rst_out_state", out_state,       128'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        saw_valid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("midrun_no_result", 128'(saw_valid), 128'd0);

        // Backpressure: result must stay put while inputs wiggle.
        bp_exp = ref_sub(128'h0123456789abcdeffedcba9876543210, 1'b0);
        applyStimulus(128'h0123456789abcdeffedcba9876543210, 1'b0, 1'b0, res, lat);
        checkOutput("bp_result", res, bp_exp);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_state   = {$urandom, $urandom, $urandom, $urandom};
            in_valid   = 1'($urandom_range(0, 1));
            in_inverse = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checkOutput("bp_out_state", out_state,       bp_exp);
            checkOutput("bp_in_ready",  128'(in_ready),  128'd0);
            checkOutput("bp_out_valid", 128'(out_valid), 128'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_in_ready",  128'(in_ready),  128'd1);
        checkOutput("bp_release_out_valid", 128'(out_valid), 128'd0);

        // Latency sweep over LANES = 1, 2, 8, 16.
        exp_lat = '{16, 8, 2, 1};
        for (int g = 0; g < 4; g++) begin
            sw_lat[g] = 0;
            sw_res[g] = '0;
        end
        @(negedge clk);
        sw_state = VEC_IN;
        sw_valid = 1'b1;
        @(posedge clk);
        #1;
        sw_valid = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++) begin
                if (sw_out_valid[g] && sw_lat[g] == 0) begin
                    sw_lat[g] = k;
                    sw_res[g] = sw_out_state[g];
                end
            end
        end
        for (int g = 0; g < 4; g++) begin
            checkOutput($sformatf("sweep_latency_%0d", g), 128'(sw_lat[g]), 128'(exp_lat[g]));
            checkOutput($sformatf("sweep_result_%0d", g),  sw_res[g],       VEC_FWD);
        end

        // Back-to-back random traffic with random backpressure.
        for (int i = 0; i < 100; i++) begin
            rand_states[i] = {$urandom, $urandom, $urandom, $urandom};
            rand_modes[i]  = 1'($urandom_range(0, 1));
        end
        sent     = 0;
        received = 0;
        for (int cyc = 0; cyc < 5000 && received < 100; cyc++) begin
            @(negedge clk);
            in_valid = (sent < 100);
            if (sent < 100) begin
                in_state   = rand_states[sent];
                in_inverse = rand_modes[sent];
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rand_extra_output", 128'(exp_q.size()), 128'd1);
                end else begin
                    checkOutput("rand_out", out_state, exp_q.pop_front());
                end
                received++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sub(in_state, eff_mode(in_inverse)));
                sent++;
            end
        end
        in_valid = 1'b0;
        checkOutput("rand_received", 128'(received), 128'd100);
        checkOutput("rand_leftover", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
